// File: rtl/i2c_led_pwm.sv
// I2C target with LED_CNT PWM brightness channels and an auto-incrementing register pointer.
// Define I2C_LED_PWM_READ_EN to build read transactions; otherwise R/W=1 addresses are NACKed.
module i2c_led_pwm #(
  parameter logic [6:0] ADDRESS     = 7'h4A,
  parameter int         LED_CNT     = 4,
  parameter int         PWM_WIDTH   = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scl_i,
  output logic               scl_o,
  input  logic               sda_i,
  output logic               sda_o,
  output logic [LED_CNT-1:0] led_o
);

  // state      | meaning
  // IDLE       | bus free, waiting for START
  // ADDR       | shifting in address + R/W
  // ADDR_ACK   | driving address ACK
  // PTR        | shifting in register pointer
  // PTR_ACK    | driving pointer ACK
  // WDATA      | shifting in duty byte
  // WDATA_ACK  | driving data ACK
  // RDATA      | shifting out duty byte
  // RDATA_MACK | sampling master ACK/NACK
  // WAIT       | not addressed, ignore bus until START/STOP
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, WAIT
  } state_t;

`ifdef I2C_LED_PWM_READ_EN
  localparam bit READ_OK = 1'b1;
`else
  localparam bit READ_OK = 1'b0;
`endif
  localparam logic [PWM_WIDTH-1:0] CNT_TOP = {{(PWM_WIDTH-1){1'b1}}, 1'b0};

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d, scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  state_t                 state;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift;
  logic [7:0]             ptr, ptr_inc;
  logic                   in_range, wr_en;
  logic [PWM_WIDTH-1:0]   wr_val;
  logic [PWM_WIDTH-1:0]   duty   [LED_CNT];
  logic [PWM_WIDTH-1:0]   shadow [LED_CNT];
  logic [PWM_WIDTH-1:0]   cnt;

  assign scl_o = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // Out-of-range pointers wrap to 0 just like the last valid channel.
  assign ptr_inc  = (ptr >= 8'(LED_CNT - 1)) ? 8'd0 : ptr + 8'd1;
  assign in_range = (ptr < 8'(LED_CNT));
  assign wr_val   = shift[7 -: PWM_WIDTH];
  assign wr_en    = (state == WDATA) && scl_fall && (bit_cnt == 4'd8) &&
                    !start_det && !stop_det && in_range;

`ifdef I2C_LED_PWM_READ_EN
  logic [7:0] rd_byte;
  always_comb begin
    rd_byte = '0;
    for (int n = 0; n < LED_CNT; n++)
      if (ptr == 8'(n)) rd_byte[7 -: PWM_WIDTH] = duty[n];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      ptr     <= '0;
      sda_o   <= 1'b1;
    end else if (start_det) begin
      state   <= ADDR;
      bit_cnt <= '0;
      sda_o   <= 1'b1;
    end else if (stop_det) begin
      state <= IDLE;
      sda_o <= 1'b1;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift   <= {shift[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            if (state == ADDR) begin
              if (shift[7:1] == ADDRESS && (!shift[0] || READ_OK)) begin
                state <= ADDR_ACK;
                sda_o <= 1'b0;
              end else begin
                state <= WAIT;
                sda_o <= 1'b1;
              end
            end else if (state == PTR) begin
              state <= PTR_ACK;
              sda_o <= 1'b0;
              ptr   <= shift;
            end else begin
              state <= WDATA_ACK;
              sda_o <= 1'b0;
              ptr   <= ptr_inc;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
`ifdef I2C_LED_PWM_READ_EN
          if (shift[0]) begin
            state <= RDATA;
            sda_o <= rd_byte[7];
            shift <= {rd_byte[6:0], 1'b0};
          end else
`endif
          begin
            state <= PTR;
            sda_o <= 1'b1;
          end
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          state <= WDATA;
          sda_o <= 1'b1;
        end
`ifdef I2C_LED_PWM_READ_EN
        RDATA: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state <= RDATA_MACK;
              sda_o <= 1'b1;
            end else begin
              sda_o <= shift[7];
              shift <= {shift[6:0], 1'b0};
            end
          end
        end
        // bit_cnt=9 marks a master ACK seen; the pointer is already advanced for the next byte.
        RDATA_MACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr     <= ptr_inc;
              bit_cnt <= 4'd9;
            end else begin
              state <= WAIT;
            end
          end else if (scl_fall && bit_cnt == 4'd9) begin
            state   <= RDATA;
            bit_cnt <= '0;
            sda_o   <= rd_byte[7];
            shift   <= {rd_byte[6:0], 1'b0};
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < LED_CNT; n++) duty[n] <= '0;
    end else begin
      for (int n = 0; n < LED_CNT; n++)
        if (wr_en && ptr == 8'(n)) duty[n] <= wr_val;
    end
  end

  // Shadow loads on the wrap edge; a write landing on that edge is taken directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      led_o <= '0;
      for (int n = 0; n < LED_CNT; n++) shadow[n] <= '0;
    end else begin
      cnt <= (cnt == CNT_TOP) ? '0 : cnt + 1'b1;
      for (int n = 0; n < LED_CNT; n++) begin
        led_o[n] <= (cnt < shadow[n]);
        if (cnt == CNT_TOP)
          shadow[n] <= (wr_en && ptr == 8'(n)) ? wr_val : duty[n];
      end
    end
  end

endmodule

// File: tb/tb_i2c_led_pwm.sv
// Bench for i2c_led_pwm: bit-banged open-drain I2C master, table + random writes,
// and a register/pointer model whose PWM expectation is the high-time count per period.
`timescale 1ns/1ps
module tb_i2c_led_pwm;
  localparam int LED_CNT = 4;
  localparam int Q       = 8;
  localparam int PERIOD  = 255;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               scl_m = 1'b1, sda_m = 1'b1;
  logic               scl_o, sda_o, scl_line, sda_line;
  logic [LED_CNT-1:0] led_o;

  assign scl_line = scl_m & scl_o;
  assign sda_line = sda_m & sda_o;

  i2c_led_pwm #(.ADDRESS(7'h4A), .LED_CNT(LED_CNT), .PWM_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_line), .scl_o(scl_o),
    .sda_i(sda_line), .sda_o(sda_o), .led_o(led_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sda_low_cnt = 0;
  always @(negedge clk) if (sda_o === 1'b0) sda_low_cnt++;

  int         duty_m [LED_CNT];
  int         ptr_m = 0;
  logic [7:0] tx_q [$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] ptr;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         ack;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    @(negedge clk) b = sda_line;
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] v, output bit ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(b);
    ack = !b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic do_write(input bit with_stop, output int acks);
    bit a;
    acks = 0;
    i2c_start();
    foreach (tx_q[i]) begin
      write_byte(tx_q[i], a);
      if (a) acks++;
    end
    if (with_stop) i2c_stop();
  endtask

  // Register-map rules: pointer byte, then each data byte lands at the pointer (if valid) and advances it.
  task automatic model_write();
    if (tx_q.size() < 2 || tx_q[0] != 8'h94) return;
    ptr_m = int'(tx_q[1]);
    for (int i = 2; i < tx_q.size(); i++) begin
      if (ptr_m < LED_CNT) duty_m[ptr_m] = int'(tx_q[i]);
      ptr_m = (ptr_m < LED_CNT - 1) ? ptr_m + 1 : 0;
    end
  endtask

  // Let two wraps pass so shadows are settled, then count high clocks over one full period.
  task automatic pwm_check(input string tag);
    int hi [LED_CNT];
    foreach (hi[n]) hi[n] = 0;
    repeat (2 * PERIOD + 8) @(posedge clk);
    for (int t = 0; t < PERIOD; t++) begin
      @(negedge clk);
      for (int n = 0; n < LED_CNT; n++) if (led_o[n]) hi[n]++;
    end
    for (int n = 0; n < LED_CNT; n++)
      check($sformatf("%s_pwm_ch%0d", tag, n), hi[n], duty_m[n]);
  endtask

  initial begin
    int         acks, low0;
    bit         a;
    logic [7:0] rv;

    foreach (duty_m[n]) duty_m[n] = 0;
    tbl[0] = '{8'h94, 8'h00, 1, 8'h80, 8'h00, 1'b1};
    tbl[1] = '{8'h94, 8'h03, 2, 8'h10, 8'h20, 1'b1};
    tbl[2] = '{8'h96, 8'h01, 1, 8'h55, 8'h00, 1'b0};
    tbl[3] = '{8'h94, 8'h01, 2, 8'hFF, 8'h00, 1'b1};
    tbl[4] = '{8'h94, 8'h07, 2, 8'h33, 8'h44, 1'b1};

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_sda_o", int'(sda_o), 1);
    check("rst_scl_o", int'(scl_o), 1);
    check("rst_led_o", int'(led_o), 0);
    @(posedge clk);
    rst_n = 1'b1;
    pwm_check("rst");

    foreach (tbl[k]) begin
      tx_q.delete();
      tx_q.push_back(tbl[k].addr);
      tx_q.push_back(tbl[k].ptr);
      tx_q.push_back(tbl[k].d0);
      if (tbl[k].n > 1) tx_q.push_back(tbl[k].d1);
      low0 = sda_low_cnt;
      do_write(1'b1, acks);
      check($sformatf("vec%0d_acks", k), acks, tbl[k].ack ? tx_q.size() : 0);
      if (!tbl[k].ack) check($sformatf("vec%0d_sda_driven", k), sda_low_cnt - low0, 0);
      model_write();
      pwm_check($sformatf("vec%0d", k));
    end

    for (int r = 0; r < 6; r++) begin
      int nb;
      tx_q.delete();
      tx_q.push_back(8'h94);
      tx_q.push_back(8'($urandom_range(0, 6)));
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      do_write(1'b1, acks);
      check($sformatf("rnd%0d_acks", r), acks, tx_q.size());
      model_write();
      pwm_check($sformatf("rnd%0d", r));
    end

    tx_q.delete();
    tx_q.push_back(8'h94);
    tx_q.push_back(8'h01);
    do_write(1'b0, acks);
    check("rd_ptr_acks", acks, 2);
    model_write();
    i2c_start();
    write_byte(8'h95, a);
`ifdef I2C_LED_PWM_READ_EN
    check("rd_addr_ack", int'(a), 1);
    read_byte(1'b0, rv);
    check("rd_byte0", int'(rv), duty_m[1]);
    read_byte(1'b1, rv);
    check("rd_byte1", int'(rv), duty_m[2]);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rd_nack_sda_released", int'(sda_o), 1);
`else
    check("rd_addr_nack", int'(a), 0);
    rv = 8'h00;
`endif
    i2c_stop();
    pwm_check("rd");

    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(tx_q[0][i]);
    sda_m = 1'b1;
    wait_q();
    @(negedge clk);
    check("midrst_ack_driven", int'(sda_o), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst_sda_async", int'(sda_o), 1);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    foreach (duty_m[n]) duty_m[n] = 0;
    ptr_m = 0;
    pwm_check("midrst");
    check("scl_o_const", int'(scl_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
